// File: rtl/pulpemu_rst_pkg.sv
// Shared types and default constants for the pulpemu reset sequencer.
// Optional feature macro: PULPEMU_RST_CAUSE_EN (sticky reset-cause register).
package pulpemu_rst_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    RESET    = 2'd0,
    DEBOUNCE = 2'd1,
    RELEASE  = 2'd2,
    RUN      = 2'd3
  } rst_state_e;

  // Default parameter values
  localparam int unsigned DEF_NUM_SRC         = 32'd2;
  localparam int unsigned DEF_SYNC_STAGES     = 32'd2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1024;
  localparam int unsigned DEF_NUM_DOMAINS     = 32'd3;
  localparam int unsigned DEF_RELEASE_GAP     = 32'd16;

  // Larger of two unsigned values, used to size the shared counter
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    int unsigned r;
    if (a > b) begin
      r = a;
    end else begin
      r = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/pulpemu_rst_sync.sv
// One-bit multi-stage synchroniser for a raw asynchronous reset source.
// The chain resets to RST_VAL so the source reads as asserted until the
// first clean samples have propagated through all stages.
module pulpemu_rst_sync #(
  parameter int unsigned STAGES  = 32'd2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the synchroniser chain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pulpemu_rst_seq.sv
// Reset sequencer for the FPGA emulation top: synchronises NUM_SRC raw reset
// sources, debounces their release and then releases NUM_DOMAINS active-low
// domain resets one after another, RELEASE_GAP cycles apart. Any active source
// re-asserts every domain at once.
// Optional feature macro: PULPEMU_RST_CAUSE_EN -- when defined, rst_cause_o is a
// sticky record of the sources that pulled the sequencer back into RESET;
// otherwise it is tied to zero and clear_cause_i is ignored.
module pulpemu_rst_seq
  import pulpemu_rst_pkg::*;
#(
  parameter int unsigned          NUM_SRC         = DEF_NUM_SRC,
  parameter logic [NUM_SRC-1:0]   SRC_ACTIVE_LOW  = 2'b01,
  parameter int unsigned          SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned          DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned          NUM_DOMAINS     = DEF_NUM_DOMAINS,
  parameter int unsigned          RELEASE_GAP     = DEF_RELEASE_GAP
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_SRC-1:0]     rst_src_i,
  input  logic                   test_mode_i,
  input  logic                   clear_cause_i,
  output logic [NUM_DOMAINS-1:0] rst_n_o,
  output logic                   rst_done_o,
  output logic [NUM_SRC-1:0]     rst_cause_o
);

  localparam int unsigned CNT_W = $clog2(max_u(DEBOUNCE_CYCLES, RELEASE_GAP) + 32'd1);
  localparam int unsigned IDX_W = (NUM_DOMAINS > 32'd1) ? $clog2(NUM_DOMAINS) : 32'd1;
  localparam int unsigned IDX_LAST_I = (NUM_DOMAINS > 32'd1) ? (NUM_DOMAINS - 32'd2) : 32'd0;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RELEASE_GAP - 32'd1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IDX_LAST_I);

  logic [NUM_SRC-1:0] src_sync_s;
  logic [NUM_SRC-1:0] src_act_s;
  logic               any_act_s;

  rst_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [NUM_DOMAINS-1:0] rst_n_q;
  logic                   done_q;

  // Per-source synchroniser; flops power up holding the asserted level
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    pulpemu_rst_sync #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (~SRC_ACTIVE_LOW[i])
    ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (rst_src_i[i]),
      .q_o    (src_sync_s[i])
    );
    assign src_act_s[i] = SRC_ACTIVE_LOW[i] ? ~src_sync_s[i] : src_sync_s[i];
  end

  assign any_act_s = |src_act_s;

  // Sequencer FSM: debounce, staged release, immediate re-assert on any source
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RESET;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RESET: begin
          cnt_q   <= '0;
          idx_q   <= '0;
          rst_n_q <= '0;
          done_q  <= 1'b0;
          if (!any_act_s) begin
            state_q <= DEBOUNCE;
          end else begin
            state_q <= RESET;
          end
        end
        DEBOUNCE: begin
          if (any_act_s) begin
            state_q <= RESET;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
          end else if (cnt_q == DEB_LAST) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= NUM_DOMAINS'(1'b1);
            if (NUM_DOMAINS == 32'd1) begin
              state_q <= RUN;
              done_q  <= 1'b1;
            end else begin
              state_q <= RELEASE;
              done_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (any_act_s) begin
            state_q <= RESET;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
          end else if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            idx_q <= idx_q + IDX_W'(1);
            for (int k = 0; k < int'(NUM_DOMAINS); k++) begin
              if (k == int'(idx_q) + 1) begin
                rst_n_q[k] <= 1'b1;
              end
            end
            if (idx_q == IDX_LAST) begin
              state_q <= RUN;
              done_q  <= 1'b1;
            end else begin
              state_q <= RELEASE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (any_act_s) begin
            state_q <= RESET;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
          end else begin
            state_q <= RUN;
          end
        end
        default: begin
          state_q <= RESET;
          cnt_q   <= '0;
          idx_q   <= '0;
          rst_n_q <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PULPEMU_RST_CAUSE_EN
  logic [NUM_SRC-1:0] cause_q;
  logic               capture_s;

  // Every live state falls back to RESET exactly when a source is active
  assign capture_s = (state_q != RESET) && any_act_s;

  // Sticky cause record; a capture on the same edge overrides a clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cause_q <= '0;
    end else if (capture_s) begin
      cause_q <= cause_q | src_act_s;
    end else if (clear_cause_i) begin
      cause_q <= '0;
    end else begin
      cause_q <= cause_q;
    end
  end

  assign rst_cause_o = cause_q;
`else
  logic unused_clear_cause_s;
  assign unused_clear_cause_s = clear_cause_i;
  assign rst_cause_o = '0;
`endif

  // DFT bypass hands the power-on reset straight to every domain
  assign rst_n_o    = test_mode_i ? {NUM_DOMAINS{rst_ni}} : rst_n_q;
  assign rst_done_o = test_mode_i ? rst_ni : done_q;

endmodule
